// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and default constants for the pipeline sequencing controller.
//   pipe_state_t      : controller state (RUN, DRAIN, HALTED)
//   DEF_REG_ADDR_W    : default register-index width
//   DEF_DRAIN_CYC     : default drain length after a halt leaves ID
//   DEF_CNT_W         : default performance counter width
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_DRAIN_CYC  = 3;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous active-low clear
//   inc    in  1      count one event this cycle
//   count  out WIDTH  current (saturated) count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count events until every bit is set, then hold there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Sequencing controller for the in-order 5-stage pipeline. Produces per-stage
// load enables, bubble-insert flushes and the PC redirect select, arbitrating
// memory-busy freezes, taken-branch flushes, load-use stalls and halt draining.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   mem_busy                   MEM access still in progress (freeze all)
//   branch_taken               EX resolved a taken branch/jump
//   ex_is_load, ex_rd          load in EX and its destination register
//   id_rs1/2, id_use_rs1/2     ID source registers and their use flags
//   halt_req                   ID holds a halt instruction
//   resume                     restart pulse from HALTED
//   en_if..en_wb               pipeline register load enables
//   flush_id, flush_ex         IF/ID and ID/EX bubble inserts
//   pc_sel                     1 selects the branch target for the PC
//   halted                     pipeline drained and stopped
//   stall_cnt, flush_cnt       saturating event counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int DRAIN_CYC  = DEF_DRAIN_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_busy,
    input  logic                  branch_taken,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  en_if,
    output logic                  en_id,
    output logic                  en_ex,
    output logic                  en_mem,
    output logic                  en_wb,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic                  pc_sel,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    pipe_state_t   state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          load_use;
    logic          stall_inc, flush_inc;

    // Register x0 is hardwired to zero, so a load targeting it never creates
    // a real dependency.
    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Output decode and next state. Everything defaults to a frozen pipeline
    // so that an asserted reset forces all controls low without waiting for
    // a clock edge.
    always_comb begin
        en_if     = 1'b0;
        en_id     = 1'b0;
        en_ex     = 1'b0;
        en_mem    = 1'b0;
        en_wb     = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        pc_sel    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        state_nxt = state;
        drain_nxt = drain_cnt;

        if (reset) begin
            unique case (state)
                RUN: begin
                    if (mem_busy) begin
                        // Everything frozen; a pending branch stays in EX.
                        stall_inc = 1'b1;
                    end else if (branch_taken) begin
                        {en_if, en_id, en_ex, en_mem, en_wb} = 5'b11111;
                        flush_id  = 1'b1;
                        flush_ex  = 1'b1;
                        pc_sel    = 1'b1;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        // Hold IF and ID, push one bubble into EX.
                        {en_ex, en_mem, en_wb} = 3'b111;
                        flush_ex  = 1'b1;
                        stall_inc = 1'b1;
                    end else if (halt_req) begin
                        {en_if, en_id, en_ex, en_mem, en_wb} = 5'b11111;
                        state_nxt = DRAIN;
                        drain_nxt = DW'(DRAIN_CYC);
                    end else begin
                        {en_if, en_id, en_ex, en_mem, en_wb} = 5'b11111;
                    end
                end

                DRAIN: begin
                    if (mem_busy) begin
                        stall_inc = 1'b1;
                    end else if (branch_taken) begin
                        // The halt is younger than the branch, so it gets
                        // flushed and normal execution resumes.
                        {en_if, en_id, en_ex, en_mem, en_wb} = 5'b11111;
                        flush_id  = 1'b1;
                        flush_ex  = 1'b1;
                        pc_sel    = 1'b1;
                        flush_inc = 1'b1;
                        state_nxt = RUN;
                        drain_nxt = '0;
                    end else begin
                        // Fetch stopped; bubbles enter ID while the older
                        // instructions retire.
                        {en_id, en_ex, en_mem, en_wb} = 4'b1111;
                        flush_id  = 1'b1;
                        drain_nxt = drain_cnt - 1'b1;
                        if (drain_cnt == DW'(1)) begin
                            state_nxt = HALTED;
                        end
                    end
                end

                HALTED: begin
                    if (resume) begin
                        state_nxt = RUN;
                    end
                end

                default: begin
                    state_nxt = RUN;
                    drain_nxt = '0;
                end
            endcase
        end
    end

    assign halted = reset && (state == HALTED);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Directed bench for pipe_ctrl with DRAIN_CYC=3 and 4-bit counters so that
// saturation is reachable quickly. Inputs change just after each falling edge
// and outputs are sampled 1 time unit later, away from the rising edge.
module tb_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic       mem_busy;
    logic       branch_taken;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       halt_req;
    logic       resume;
    logic       en_if, en_id, en_ex, en_mem, en_wb;
    logic       flush_id, flush_ex, pc_sel, halted;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    logic [4:0] en_vec;
    logic [3:0] ctl_vec;

    int checks;
    int failures;

    assign en_vec  = {en_if, en_id, en_ex, en_mem, en_wb};
    assign ctl_vec = {flush_id, flush_ex, pc_sel, halted};

    pipe_ctrl #(
        .REG_ADDR_W (5),
        .DRAIN_CYC  (3),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_busy     (mem_busy),
        .branch_taken (branch_taken),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .halt_req     (halt_req),
        .resume       (resume),
        .en_if        (en_if),
        .en_id        (en_id),
        .en_ex        (en_ex),
        .en_mem       (en_mem),
        .en_wb        (en_wb),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex),
        .pc_sel       (pc_sel),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs after the falling edge, then settle.
    task automatic applyStimulus(input logic mb, input logic bt, input logic ld,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1,
                                 input logic u2, input logic hr, input logic rs);
        @(negedge clk);
        mem_busy     = mb;
        branch_taken = bt;
        ex_is_load   = ld;
        ex_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        halt_req     = hr;
        resume       = rs;
        #1;
    endtask

    task automatic quiet();
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [4:0] en_exp,
                            input logic [3:0] ctl_exp);
        checkOutput({tag, ".en"}, 16'(en_vec), 16'(en_exp));
        checkOutput({tag, ".ctl"}, 16'(ctl_vec), 16'(ctl_exp));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        mem_busy     = 1'b0;
        branch_taken = 1'b0;
        ex_is_load   = 1'b0;
        ex_rd        = 5'd0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        halt_req     = 1'b0;
        resume       = 1'b0;

        // Reset state
        #3;
        checkCtl("reset", 5'b00000, 4'b0000);
        checkOutput("reset.stall_cnt", 16'(stall_cnt), 16'd0);
        checkOutput("reset.flush_cnt", 16'(flush_cnt), 16'd0);
        @(negedge clk);
        reset = 1'b1;

        quiet();
        checkCtl("run_quiet", 5'b11111, 4'b0000);

        // Load-use on rs2
        applyStimulus(0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0);
        checkCtl("load_use_rs2", 5'b00111, 4'b0100);
        checkOutput("load_use_rs2.stall_pre", 16'(stall_cnt), 16'd0);
        quiet();
        checkOutput("load_use_rs2.stall_post", 16'(stall_cnt), 16'd1);
        checkCtl("after_load_use", 5'b11111, 4'b0000);

        // Load to x0 never stalls
        applyStimulus(0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        checkCtl("load_x0", 5'b11111, 4'b0000);
        // Matching register but source not used
        applyStimulus(0, 0, 1, 5'd9, 5'd9, 5'd9, 0, 0, 0, 0);
        checkCtl("load_unused_src", 5'b11111, 4'b0000);
        // Load-use on rs1
        applyStimulus(0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 1, 0, 0);
        checkCtl("load_use_rs1", 5'b00111, 4'b0100);
        quiet();
        checkOutput("load_use_rs1.stall", 16'(stall_cnt), 16'd2);

        // Busy freezes a simultaneous branch for 3 cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
            checkCtl("busy_branch", 5'b00000, 4'b0000);
        end
        applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkCtl("branch_after_busy", 5'b11111, 4'b1110);
        checkOutput("busy.stall", 16'(stall_cnt), 16'd5);
        quiet();
        checkOutput("branch.flush_cnt", 16'(flush_cnt), 16'd1);

        // Halt and drain
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        checkCtl("halt_req", 5'b11111, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            quiet();
            checkCtl("drain", 5'b01111, 4'b1000);
        end
        quiet();
        checkCtl("halted", 5'b00000, 4'b0001);
        // Inputs other than resume are ignored while halted
        applyStimulus(1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0);
        checkCtl("halted_ignore", 5'b00000, 4'b0001);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        checkCtl("resume_cycle", 5'b00000, 4'b0001);
        checkOutput("halted.stall", 16'(stall_cnt), 16'd5);
        checkOutput("halted.flush", 16'(flush_cnt), 16'd1);
        quiet();
        checkCtl("after_resume", 5'b11111, 4'b0000);

        // Halt cancelled by a branch in the second drain cycle
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        quiet();
        checkCtl("cancel_drain1", 5'b01111, 4'b1000);
        applyStimulus(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkCtl("cancel_branch", 5'b11111, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            quiet();
            checkCtl("cancel_run", 5'b11111, 4'b0000);
        end
        checkOutput("cancel.flush_cnt", 16'(flush_cnt), 16'd2);

        // Busy during drain holds the drain counter
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        quiet();
        checkCtl("hold_drain1", 5'b01111, 4'b1000);
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkCtl("hold_busy", 5'b00000, 4'b0000);
        quiet();
        checkCtl("hold_drain2", 5'b01111, 4'b1000);
        checkOutput("hold.stall", 16'(stall_cnt), 16'd6);
        quiet();
        checkCtl("hold_drain3", 5'b01111, 4'b1000);
        quiet();
        checkCtl("hold_halted", 5'b00000, 4'b0001);
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        quiet();
        checkCtl("hold_resumed", 5'b11111, 4'b0000);

        // Stall counter saturation
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 0);
        end
        quiet();
        checkOutput("sat.stall", 16'(stall_cnt), 16'd15);
        checkOutput("sat.flush", 16'(flush_cnt), 16'd2);

        // Reset while halted
        applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) quiet();
        quiet();
        checkCtl("pre_reset_halted", 5'b00000, 4'b0001);
        reset = 1'b0;
        #1;
        checkCtl("reset_halted", 5'b00000, 4'b0000);
        checkOutput("reset_halted.stall", 16'(stall_cnt), 16'd0);
        checkOutput("reset_halted.flush", 16'(flush_cnt), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        quiet();
        checkCtl("after_reset_halted", 5'b11111, 4'b0000);

        // Reset while busy
        applyStimulus(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        quiet();
        checkOutput("busy_again.stall", 16'(stall_cnt), 16'd1);
        applyStimulus(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        checkCtl("reset_busy", 5'b00000, 4'b0000);
        checkOutput("reset_busy.stall", 16'(stall_cnt), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        quiet();
        checkCtl("after_reset_busy", 5'b11111, 4'b0000);

        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central sequencing controller for the in-order 5-stage pipeline (IF, ID, EX, MEM, WB). It drives per-stage enables and synchronous bubble-inserts for the pipeline register banks, built from the team's D flip-flop cells, and selects the PC redirect. It arbitrates memory-busy freezes, taken-branch flushes, load-use stalls and halt draining. It also keeps saturating stall and flush performance counters.

## Interface
- `REG_ADDR_W`, default 5: register-index width.
- `DRAIN_CYC`, default 3: non-frozen cycles needed to empty EX, MEM and WB after a halt leaves ID.
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_busy`  in  1  MEM stage multi-cycle access not complete.
- `branch_taken`  in  1  EX resolved a taken branch or jump this cycle.
- `ex_is_load`  in  1  EX holds a load.
- `ex_rd`  in  REG_ADDR_W  EX destination register.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  ID source registers.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction reads that source.
- `halt_req`  in  1  ID holds a halt instruction.
- `resume`  in  1  one-cycle pulse that restarts from HALTED.
- `en_if`, `en_id`, `en_ex`, `en_mem`, `en_wb`  out  1 each  pipeline register load enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- `flush_id`, `flush_ex`  out  1 each  IF/ID or ID/EX loads a bubble this edge (only meaningful when the matching enable is 1).
- `pc_sel`  out  1  1 selects the branch target for the PC.
- `halted`  out  1  pipeline drained and stopped.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- States: RUN, DRAIN, HALTED. Reset enters RUN, drain counter 0, both perf counters 0.
- `load_use` = `ex_is_load` & (`ex_rd` != 0) & ((`id_use_rs1` & `ex_rd` == `id_rs1`) | (`id_use_rs2` & `ex_rd` == `id_rs2`)).
- Priority within RUN and DRAIN is fixed: mem_busy, then branch_taken, then load_use, then halt_req.
- **mem_busy:** all five enables 0, flushes 0, pc_sel 0. State and drain counter hold. A simultaneous branch is serviced on the first cycle after busy clears, because EX is frozen and still holds the branch.
- **branch_taken:** all enables 1, `flush_id`=1, `flush_ex`=1, `pc_sel`=1, `flush_cnt`++.
  - In DRAIN, a taken branch cancels the halt (the halt is younger and is flushed), and the state returns to RUN.
- **load_use** (RUN only): `en_if`=0, `en_id`=0, `flush_ex`=1; EX, MEM and WB enabled. `stall_cnt`++.
- **halt_req** (RUN, none of the above): normal advance this cycle; next state DRAIN; drain counter loaded with DRAIN_CYC.
- **DRAIN:** `en_if`=0, `flush_id`=1, other enables 1.
  - The counter decrements each non-frozen cycle.
  - When the counter is 1 and decrements, the next state is HALTED.
  - load_use and halt_req are ignored, since ID holds bubbles.
- **HALTED:** all enables 0, `halted`=1.
  - `resume` moves to RUN; `halted` falls the next cycle.
  - Other inputs are ignored.
- **Normal RUN:** all enables 1, flushes 0, pc_sel 0.
- `stall_cnt` also increments on every mem_busy cycle in RUN or DRAIN.
- Both counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Enables, flushes and `pc_sel` are combinational from the current state and inputs, so they take effect at the same edge. Zero-cycle latency.
- State, drain counter and perf counters are registered and update on the rising edge.
- While `reset` is low, regardless of clock, the outputs are forced:
  - all enables 0, flushes 0, `pc_sel` 0, `halted` 0;
  - counters asynchronously cleared to 0.
- Reset in DRAIN or HALTED returns to RUN. The first edge after deassertion behaves as RUN.
- Load-use costs exactly 1 bubble cycle per occurrence.
- From the halt_req cycle, `halted` rises after DRAIN_CYC+1 non-frozen edges.

## Structure
- `pipe_ctrl_pkg` holds:
  - the `pipe_state_t` enum (RUN, DRAIN, HALTED);
  - the default constants for DRAIN_CYC and CNT_W.
- Sub-module `sat_counter` (parameter width; inputs inc and async active-low reset; saturating output), instantiated twice.
- The FSM, hazard compare and output decode stay in `pipe_ctrl`.

## Test plan
- **Load-use:** ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → en_if=en_id=0, flush_ex=1, other enables 1, stall_cnt 0→1. Repeat with ex_rd=0 → no stall.
- **Busy vs branch:** mem_busy=1 for 3 cycles with branch_taken=1 throughout → enables 0 and pc_sel 0 for 3 cycles. The 4th cycle gives pc_sel=1, flush_id=flush_ex=1, flush_cnt=1.
- **Halt:** halt_req pulse with DRAIN_CYC=3, no hazards → en_if=0 for 3 cycles, halted=1 on the 4th edge. resume → RUN, all enables 1.
- **Halt cancel:** branch_taken in the second DRAIN cycle → pc_sel=1, state RUN, halted never asserts.
- **Saturation:** CNT_W=4, 20 load-use cycles → stall_cnt stays 15.
- **Reset mid-operation:** reset low while HALTED or with mem_busy=1 → all outputs 0 immediately, counters 0. After release with quiet inputs, all enables 1 on the next cycle.
